// File: rtl/debounce_pair_pkg.sv
// Shared constants and helpers for the debounce blocks.
package debounce_pair_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter and
// registered rise/fall pulses aligned with the clean level change.
module debounce_chan
  import debounce_pair_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Follow s2 only after it has disagreed with clean for STABLE_CYCLES
  // consecutive edges; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        clean <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debounce_pair.sv
// N independent debounce channels feeding the gate inputs
// (clean_out[0] = a, clean_out[1] = b) plus per-channel edge pulses.
module debounce_pair
  import debounce_pair_pkg::*;
#(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] clean_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int CNT_W = clog2(STABLE_CYCLES + 1);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("debounce_pair: STABLE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_in[i]),
      .clean(clean_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule
